// File: rtl/pe_fxp_param.sv
// Weight-stationary systolic PE with parametrised Q-format MAC, double-buffered
// weights, optional saturation and a sticky overflow flag.
module pe_fxp_param #(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 8,
    parameter int SATURATE   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] pe_psum_in,
    input  logic [DATA_WIDTH-1:0] pe_weight_in,
    input  logic                  pe_accept_w_in,
    input  logic [DATA_WIDTH-1:0] pe_input_in,
    input  logic                  pe_valid_in,
    input  logic                  pe_switch_in,
    input  logic                  pe_clear_ovf_in,
    output logic [DATA_WIDTH-1:0] pe_psum_out,
    output logic [DATA_WIDTH-1:0] pe_weight_out,
    output logic                  pe_accept_w_out,
    output logic [DATA_WIDTH-1:0] pe_input_out,
    output logic                  pe_valid_out,
    output logic                  pe_switch_out,
    output logic                  pe_weight_loaded_out,
    output logic                  pe_overflow_out
);

    localparam int DW = DATA_WIDTH;
    localparam int PW = 2 * DATA_WIDTH;
    localparam logic [DW-1:0] MaxVal = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0] MinVal = {1'b1, {(DW-1){1'b0}}};
    localparam logic [PW-1:0] RoundConst = PW'(1) << (FRAC_BITS - 1);

    logic [DW-1:0] weightBg_q, weightBg_d;
    logic [DW-1:0] weightAct_q, weightAct_d;
    logic          loaded_q, loaded_d;
    logic          overflow_q, overflow_d;
    logic [DW-1:0] psum_q, psum_d;
    logic [DW-1:0] weightFwd_q, weightFwd_d;
    logic          accept_q, accept_d;
    logic [DW-1:0] input_q, input_d;
    logic          valid_q, valid_d;
    logic          switch_q, switch_d;

    logic signed [PW-1:0] inExt, wExt, product, rounded, shifted;
    logic [DW-1:0]        mulRes, sumRes;
    logic [DW:0]          sumExt;
    logic                 mulOvf, addOvf;

    // Operands are sign-extended to full product width so the multiply is exact.
    always_comb begin
        inExt   = {{DW{pe_input_in[DW-1]}}, pe_input_in};
        wExt    = {{DW{weightAct_q[DW-1]}}, weightAct_q};
        product = inExt * wExt;
        rounded = product + RoundConst;
        shifted = rounded >>> FRAC_BITS;
        mulOvf  = (shifted[PW-1:DW-1] != {(DW+1){shifted[DW-1]}});
        mulRes  = shifted[DW-1:0];
        if (SATURATE != 0 && mulOvf) begin
            mulRes = shifted[PW-1] ? MinVal : MaxVal;
        end
        sumExt = {mulRes[DW-1], mulRes} + {pe_psum_in[DW-1], pe_psum_in};
        addOvf = (sumExt[DW] != sumExt[DW-1]);
        sumRes = sumExt[DW-1:0];
        if (SATURATE != 0 && addOvf) begin
            sumRes = sumExt[DW] ? MinVal : MaxVal;
        end
    end

    always_comb begin
        weightBg_d  = pe_accept_w_in ? pe_weight_in : weightBg_q;
        weightAct_d = pe_switch_in ? weightBg_q : weightAct_q;
        loaded_d    = loaded_q | pe_switch_in;
        // A new overflow event on this edge takes priority over the clear request.
        overflow_d  = (pe_valid_in && (mulOvf || addOvf)) ? 1'b1 :
                      (pe_clear_ovf_in ? 1'b0 : overflow_q);
        psum_d      = pe_valid_in ? sumRes : '0;
        input_d     = pe_valid_in ? pe_input_in : input_q;
        valid_d     = pe_valid_in;
        weightFwd_d = pe_accept_w_in ? pe_weight_in : '0;
        accept_d    = pe_accept_w_in;
        switch_d    = pe_switch_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            weightBg_q  <= '0;
            weightAct_q <= '0;
            loaded_q    <= 1'b0;
            overflow_q  <= 1'b0;
            psum_q      <= '0;
            input_q     <= '0;
            valid_q     <= 1'b0;
            weightFwd_q <= '0;
            accept_q    <= 1'b0;
            switch_q    <= 1'b0;
        end else begin
            weightBg_q  <= weightBg_d;
            weightAct_q <= weightAct_d;
            loaded_q    <= loaded_d;
            overflow_q  <= overflow_d;
            psum_q      <= psum_d;
            input_q     <= input_d;
            valid_q     <= valid_d;
            weightFwd_q <= weightFwd_d;
            accept_q    <= accept_d;
            switch_q    <= switch_d;
        end
    end

    assign pe_psum_out          = psum_q;
    assign pe_weight_out        = weightFwd_q;
    assign pe_accept_w_out      = accept_q;
    assign pe_input_out         = input_q;
    assign pe_valid_out         = valid_q;
    assign pe_switch_out        = switch_q;
    assign pe_weight_loaded_out = loaded_q;
    assign pe_overflow_out      = overflow_q;

endmodule

// File: doc/pe_fxp_param.md
Name: pe_fxp_param

Overview:
Parametrised weight-stationary systolic processing element for the systolic array.
- Generalises the 16-bit PE to any data width and fractional split, with optional saturation and round-half-up fixed-point MAC.
- Double-buffered weights with fully registered load/switch semantics, plus a sticky overflow flag.
- Tiles north-to-south (psum, weight, accept) and west-to-east (input, valid, switch), one register stage per hop.

Parameters:
DATA_WIDTH, 16, width of input, weight and psum (signed two's complement)
FRAC_BITS, 8, fractional bits of the Q format; legal range 1..DATA_WIDTH-1
SATURATE, 1, 1 = clamp results to the signed range; 0 = wrap (truncate to DATA_WIDTH)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
pe_psum_in  input  DATA_WIDTH  signed partial sum from north
pe_weight_in  input  DATA_WIDTH  signed weight from north
pe_accept_w_in  input  1  weight on pe_weight_in is valid for this PE column
pe_input_in  input  DATA_WIDTH  signed activation from west
pe_valid_in  input  1  activation/psum valid
pe_switch_in  input  1  promote background weight to active
pe_clear_ovf_in  input  1  synchronous clear of the sticky overflow flag
pe_psum_out  output  DATA_WIDTH  registered MAC result to south
pe_weight_out  output  DATA_WIDTH  registered weight forward to south
pe_accept_w_out  output  1  registered accept forward
pe_input_out  output  DATA_WIDTH  registered activation forward to east
pe_valid_out  output  1  registered valid forward
pe_switch_out  output  1  registered switch forward
pe_weight_loaded_out  output  1  active weight register holds a switched-in weight
pe_overflow_out  output  1  sticky: a saturation/wrap event occurred on a valid cycle

Behaviour:
- Reset (async, any time, including mid-stream): every output and internal register is 0, including weight_bg, weight_act and the loaded/overflow flags. The first edge after deassert operates normally.
- All outputs are registered with 1-cycle latency. There are no combinational in-to-out paths.
- Weight background register: on an edge with pe_accept_w_in=1, weight_bg <= pe_weight_in.
- Weight active register: on an edge with pe_switch_in=1, weight_act <= weight_bg (the value held before this edge), and weight_loaded <= 1.
- Accept and switch on the same edge: weight_act takes the old weight_bg; the new pe_weight_in lands in weight_bg only.
- Multiply:
  - Full product p = in*weight_act at 2*DATA_WIDTH bits.
  - Round half up: p_r = (p + 2^(FRAC_BITS-1)) >>> FRAC_BITS (arithmetic shift).
  - SATURATE=1: clamp p_r to [-2^(DW-1), 2^(DW-1)-1]. SATURATE=0: take the low DATA_WIDTH bits.
- Add:
  - s = m + pe_psum_in computed at DATA_WIDTH+1 bits, then clamped or wrapped the same way.
  - Overflow event = multiply or add result outside the signed range.
- On an edge with pe_valid_in=1: pe_psum_out <= s; pe_input_out <= pe_input_in; pe_valid_out <= 1.
- On an edge with pe_valid_in=0: pe_psum_out <= 0; pe_input_out holds its previous value; pe_valid_out <= 0.
- Forwarding:
  - pe_weight_out <= pe_accept_w_in ? pe_weight_in : 0.
  - pe_accept_w_out <= pe_accept_w_in.
  - pe_switch_out <= pe_switch_in.
  - Forwarding is independent of pe_valid_in.
- Overflow flag:
  - Set on an edge where pe_valid_in=1 and an overflow event occurs.
  - pe_clear_ovf_in clears it; a simultaneous set wins over clear.
  - Overflow events on cycles with pe_valid_in=0 are ignored.
- pe_weight_loaded_out: 0 from reset until the first switch edge, then stays 1. MAC still runs with weight_act=0 before the first switch.
- Switch on the same edge as valid: the MAC on that edge uses the pre-switch weight_act. The new weight applies from the next edge.

Test Plan:
- Reset then load: accept=1, weight_in=0x0080 (0.5) for 1 cycle, then switch=1 -> weight_out=0x0080 one cycle after accept; weight_loaded_out=1 after the switch edge; weight_out=0 when accept drops.
- MAC: weight_act=0x0080, input=0x0180 (1.5), psum_in=0x0100, valid=1 -> next cycle psum_out=0x01C0, input_out=0x0180, valid_out=1; valid=0 next -> psum_out=0, input_out stays 0x0180.
- Rounding: weight_act=0x0080; input=0x0001 -> psum_out=0x0001; input=0xFFFF, psum_in=0 -> psum_out=0x0000.
- Saturation, SATURATE=1: weight_act=input=0x8000 -> psum_out=0x7FFF, overflow_out=1. Then clear_ovf=1 with valid=0 -> overflow_out=0. Rerun with SATURATE=0 -> psum_out=0x0000, overflow_out=1.
- Simultaneous accept+switch with weight_bg=0x0100, weight_in=0x0200: weight_act=0x0100 and weight_bg=0x0200; the next switch gives weight_act=0x0200.
- Async reset asserted mid-stream, between clock edges, with valid=1 -> all outputs 0 immediately; loaded and overflow flags 0; the first valid after release uses weight_act=0 (psum_out=psum_in).
